battleship_core_n: RTL and testbench
====================================

BATTLESHIP_CORE_N -- requirements
Module: battleship_core_n

Interface
REQ-001 Parameter CW, default 2: coordinate bits per axis; board is 2^CW x 2^CW cells; legal range 1..4.
REQ-002 Parameter SHIPS, default 4: ships per player; legal range 1..2^(2*CW).
REQ-003 Parameter SW, default 4: width of score outputs; SHALL satisfy 2^SW > SHIPS.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  debounced level; acted on at rising edge only.
REQ-007 X  in  CW  column of the selected cell.
REQ-008 Y  in  CW  row of the selected cell.
REQ-009 pAb  in  1  player A button, debounced level; acted on at rising edge only.
REQ-010 pBb  in  1  player B button, debounced level; acted on at rising edge only.
REQ-011 phase  out  3  0 IDLE, 1 PLACE_A, 2 PLACE_B, 3 SHOOT_A, 4 SHOOT_B, 5 DONE.
REQ-012 score_a, score_b  out  SW each  hits scored by A and by B.
REQ-013 shot_valid  out  1  one-cycle pulse when a shot resolves; shot_hit  out  1  result of that shot, held until the next shot.
REQ-014 err  out  1  one-cycle pulse on a rejected placement.
REQ-015 winner  out  2  00 none, 01 A, 10 B.
REQ-016 led  out  8  {score_a[3:0], score_b[3:0]}, each zero-extended or truncated to 4 bits.

Function
REQ-017 Edge detect: one previous-value register per button; an event SHALL fire in the cycle where input=1 and the register holds 0; all effects SHALL be visible after that same clock edge (1-cycle latency).
REQ-018 Cell index SHALL be {Y,X}; two board registers occA/occB of 2^(2*CW) bits each.
REQ-019 IDLE: start event -> PLACE_A; occA, occB, scores, placement count, shot_hit and winner SHALL be cleared on this transition.
REQ-020 PLACE_A: pAb event on a free cell sets its occA bit and increments the placement count; on an occupied cell it SHALL pulse err with no other change.
REQ-021 When the SHIPS-th ship is placed, the count SHALL clear and the FSM SHALL enter PLACE_B on that same edge; PLACE_B uses pBb and occB identically, then enters SHOOT_A.
REQ-022 SHOOT_A: pAb event fires at occB[{Y,X}]; hit if the bit is 1, after which the bit SHALL be cleared and score_a incremented; a repeat shot on a cleared cell is a miss.
REQ-023 Every shot SHALL pulse shot_valid and load shot_hit; on a miss the FSM SHALL enter SHOOT_B.
REQ-024 On a hit the same player SHALL keep the turn, unless score_a reaches SHIPS, in which case the FSM enters DONE with winner=01.
REQ-025 SHOOT_B SHALL mirror SHOOT_A, using pBb, occA and score_b, and returning to SHOOT_A on a miss; winner=10.
REQ-026 The button of the non-active player SHALL be ignored, including when both buttons rise simultaneously; only the active player's event is taken.
REQ-027 The start event SHALL be ignored outside IDLE and DONE; in DONE it returns to IDLE with scores and winner held until the IDLE->PLACE_A transition.
REQ-028 Buttons SHALL be ignored in IDLE and DONE; a level held high across a phase change SHALL NOT produce a new event.
REQ-029 Scores SHALL never exceed SHIPS and SHALL NOT wrap.

Reset
REQ-030 While rst=1 on a clock edge: phase=0, scores=0, occA=occB=0, count=0, shot_valid=0, shot_hit=0, err=0, winner=00, led=0.
REQ-031 Edge registers SHALL load 0 on reset, so a button held high through reset fires one event after reset release.
REQ-032 rst mid-game SHALL abort to IDLE within one cycle, with no shot or placement taken in that cycle.

Verification
REQ-033 Defaults: start pulse, A places (0,0),(1,1),(2,2),(3,3), B places the same cells -> phase 3; A fires (0,0) -> shot_valid=1, shot_hit=1, score_a=1, phase stays 3.
REQ-034 A places (1,2) twice -> second press gives err=1 for one cycle, count unchanged, still PLACE_A.
REQ-035 In SHOOT_A, A fires (0,1) on an empty cell -> shot_hit=0, phase=4; then pAb pressed -> no effect; pBb and pAb rising in the same cycle -> only B's shot resolves.
REQ-036 A hits all 4 B ships, including a repeat of a sunk cell (miss) -> winner=01, phase=5, led=8'h40; start -> phase=0; further pAb presses ignored.
REQ-037 CW=3, SHIPS=10: cell (7,7) placement and hit index correctly; rst asserted during SHOOT_B -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/battleship_core_n_if.sv
// Control and status bundle for battleship_core_n: cell select, buttons and game status.
// The core takes the slave side; whoever drives the buttons takes the master side.
interface battleship_core_n_if #(
    parameter int CW = 2,
    parameter int SW = 4
);
    logic          start;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic          pAb;
    logic          pBb;
    logic [2:0]    phase;
    logic [SW-1:0] score_a;
    logic [SW-1:0] score_b;
    logic          shot_valid;
    logic          shot_hit;
    logic          err;
    logic [1:0]    winner;
    logic [7:0]    led;

    modport master (
        output start, X, Y, pAb, pBb,
        input  phase, score_a, score_b, shot_valid, shot_hit, err, winner, led
    );

    modport slave (
        input  start, X, Y, pAb, pBb,
        output phase, score_a, score_b, shot_valid, shot_hit, err, winner, led
    );
endinterface

// File: rtl/battleship_core_n.sv
// Two-player battleship game core: edge-detected buttons, placement and shooting phases,
// one occupancy bit per cell per player, scores and winner.
module battleship_core_n #(
    parameter int CW    = 2,
    parameter int SHIPS = 4,
    parameter int SW    = 4
) (
    input logic                clk,
    input logic                rst,
    battleship_core_n_if.slave bus
);
    localparam int CELLS = 1 << (2 * CW);
    // The count only ever holds 0..SHIPS-1: it clears as the last ship goes down.
    localparam int CNTW = (SHIPS > 1) ? $clog2(SHIPS) : 1;
    localparam logic [CNTW-1:0] LAST_SHIP = CNTW'(SHIPS - 1);
    localparam logic [SW-1:0]   WIN_SCORE = SW'(SHIPS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLACE_A = 3'd1,
        PLACE_B = 3'd2,
        SHOOT_A = 3'd3,
        SHOOT_B = 3'd4,
        DONE    = 3'd5
    } phase_t;

    phase_t           state, state_n;
    logic [CELLS-1:0] occ_a, occ_a_n, occ_b, occ_b_n;
    logic [CNTW-1:0]  count, count_n;
    logic [SW-1:0]    score_a, score_a_n, score_b, score_b_n;
    logic             shot_valid, shot_valid_n;
    logic             shot_hit, shot_hit_n;
    logic             err, err_n;
    logic [1:0]       winner, winner_n;
    logic             prev_start, prev_a, prev_b;
    logic             ev_start, ev_a, ev_b;
    logic [2*CW-1:0]  idx;

    assign ev_start = bus.start & ~prev_start;
    assign ev_a     = bus.pAb & ~prev_a;
    assign ev_b     = bus.pBb & ~prev_b;
    assign idx      = {bus.Y, bus.X};

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            occ_a      <= '0;
            occ_b      <= '0;
            count      <= '0;
            score_a    <= '0;
            score_b    <= '0;
            shot_valid <= 1'b0;
            shot_hit   <= 1'b0;
            err        <= 1'b0;
            winner     <= 2'b00;
            prev_start <= 1'b0;
            prev_a     <= 1'b0;
            prev_b     <= 1'b0;
        end else begin
            state      <= state_n;
            occ_a      <= occ_a_n;
            occ_b      <= occ_b_n;
            count      <= count_n;
            score_a    <= score_a_n;
            score_b    <= score_b_n;
            shot_valid <= shot_valid_n;
            shot_hit   <= shot_hit_n;
            err        <= err_n;
            winner     <= winner_n;
            prev_start <= bus.start;
            prev_a     <= bus.pAb;
            prev_b     <= bus.pBb;
        end
    end

    // NOTE: every signal written below gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_n      = state;
        occ_a_n      = occ_a;
        occ_b_n      = occ_b;
        count_n      = count;
        score_a_n    = score_a;
        score_b_n    = score_b;
        shot_valid_n = 1'b0;
        shot_hit_n   = shot_hit;
        err_n        = 1'b0;
        winner_n     = winner;

        unique case (state)
            IDLE: if (ev_start) begin
                state_n    = PLACE_A;
                occ_a_n    = '0;
                occ_b_n    = '0;
                count_n    = '0;
                score_a_n  = '0;
                score_b_n  = '0;
                shot_hit_n = 1'b0;
                winner_n   = 2'b00;
            end
            PLACE_A: if (ev_a) begin
                if (occ_a[idx]) begin
                    err_n = 1'b1;
                end else begin
                    occ_a_n[idx] = 1'b1;
                    if (count == LAST_SHIP) begin
                        count_n = '0;
                        state_n = PLACE_B;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            PLACE_B: if (ev_b) begin
                if (occ_b[idx]) begin
                    err_n = 1'b1;
                end else begin
                    occ_b_n[idx] = 1'b1;
                    if (count == LAST_SHIP) begin
                        count_n = '0;
                        state_n = SHOOT_A;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            SHOOT_A: if (ev_a) begin
                shot_valid_n = 1'b1;
                shot_hit_n   = occ_b[idx];
                // A sunk cell is cleared, so a repeat shot there resolves as a miss.
                if (occ_b[idx]) begin
                    occ_b_n[idx] = 1'b0;
                    score_a_n    = score_a + 1'b1;
                    if (score_a_n == WIN_SCORE) begin
                        state_n  = DONE;
                        winner_n = 2'b01;
                    end
                end else begin
                    state_n = SHOOT_B;
                end
            end
            SHOOT_B: if (ev_b) begin
                shot_valid_n = 1'b1;
                shot_hit_n   = occ_a[idx];
                if (occ_a[idx]) begin
                    occ_a_n[idx] = 1'b0;
                    score_b_n    = score_b + 1'b1;
                    if (score_b_n == WIN_SCORE) begin
                        state_n  = DONE;
                        winner_n = 2'b10;
                    end
                end else begin
                    state_n = SHOOT_A;
                end
            end
            DONE: if (ev_start) begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.phase      = state;
    assign bus.score_a    = score_a;
    assign bus.score_b    = score_b;
    assign bus.shot_valid = shot_valid;
    assign bus.shot_hit   = shot_hit;
    assign bus.err        = err;
    assign bus.winner     = winner;
    assign bus.led        = {4'(score_a), 4'(score_b)};
endmodule

// File: tb/tb_battleship_core_n.sv
// Bench for battleship_core_n: a default board (CW=2, SHIPS=4) and a larger one (CW=3, SHIPS=10),
// shot outcomes checked against a queue of expected results, everything else inline.
module tb_battleship_core_n;
    typedef struct packed {
        logic       hit;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [2:0] ph;
    } shot_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  rst3 = 1'b1;
    int    checks = 0;
    int    failures = 0;
    shot_t q0[$];
    shot_t q3[$];

    always #5 clk = ~clk;

    battleship_core_n_if #(.CW(2), .SW(4)) b0 ();
    battleship_core_n_if #(.CW(3), .SW(4)) b3 ();

    battleship_core_n #(.CW(2), .SHIPS(4), .SW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    battleship_core_n #(.CW(3), .SHIPS(10), .SW(4)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (b3)
    );

    function automatic shot_t mk(input logic hit, input int sa, input int sb, input int ph);
        shot_t s;
        s.hit = hit;
        s.sa  = 4'(sa);
        s.sb  = 4'(sb);
        s.ph  = 3'(ph);
        return s;
    endfunction

    // Scoreboard side: every resolved shot must match the oldest expected entry.
    always @(negedge clk) begin
        shot_t obs, exp_s;
        if (b0.shot_valid === 1'b1) begin
            checks++;
            obs = {b0.shot_hit, b0.score_a, b0.score_b, b0.phase};
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL shot0_unexpected: got shot hit=%0d sa=%0d sb=%0d ph=%0d want no shot",
                         obs.hit, obs.sa, obs.sb, obs.ph);
            end else begin
                exp_s = q0.pop_front();
                if (obs !== exp_s) begin
                    failures++;
                    $display("FAIL shot0: got hit=%0d sa=%0d sb=%0d ph=%0d want hit=%0d sa=%0d sb=%0d ph=%0d",
                             obs.hit, obs.sa, obs.sb, obs.ph, exp_s.hit, exp_s.sa, exp_s.sb, exp_s.ph);
                end
            end
        end
        if (b3.shot_valid === 1'b1) begin
            checks++;
            obs = {b3.shot_hit, b3.score_a, b3.score_b, b3.phase};
            if (q3.size() == 0) begin
                failures++;
                $display("FAIL shot3_unexpected: got shot hit=%0d sa=%0d sb=%0d ph=%0d want no shot",
                         obs.hit, obs.sa, obs.sb, obs.ph);
            end else begin
                exp_s = q3.pop_front();
                if (obs !== exp_s) begin
                    failures++;
                    $display("FAIL shot3: got hit=%0d sa=%0d sb=%0d ph=%0d want hit=%0d sa=%0d sb=%0d ph=%0d",
                             obs.hit, obs.sa, obs.sb, obs.ph, exp_s.hit, exp_s.sa, exp_s.sb, exp_s.ph);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input bit a, input bit b, input int x, input int y);
        b0.X = 2'(x); b0.Y = 2'(y); b0.pAb = a; b0.pBb = b;
        tick();
    endtask

    task automatic idle0();
        b0.pAb = 1'b0; b0.pBb = 1'b0; b0.start = 1'b0;
        tick();
    endtask

    task automatic place0(input bit a, input bit b, input int x, input int y);
        drive0(a, b, x, y);
        idle0();
    endtask

    task automatic shoot0(input bit a, input bit b, input int x, input int y, input shot_t e);
        q0.push_back(e);
        drive0(a, b, x, y);
        idle0();
    endtask

    task automatic drive3(input bit a, input bit b, input int x, input int y);
        b3.X = 3'(x); b3.Y = 3'(y); b3.pAb = a; b3.pBb = b;
        tick();
    endtask

    task automatic place3(input bit a, input bit b, input int x, input int y);
        drive3(a, b, x, y);
        b3.pAb = 1'b0; b3.pBb = 1'b0;
        tick();
    endtask

    task automatic shoot3(input bit a, input bit b, input int x, input int y, input shot_t e);
        q3.push_back(e);
        place3(a, b, x, y);
    endtask

    task automatic test_reset();
        b0.start = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({b0.phase, b0.score_a, b0.score_b, b0.shot_valid, b0.shot_hit, b0.err, b0.winner, b0.led} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs: got phase=%0d sa=%0d sb=%0d sv=%0d sh=%0d err=%0d win=%0d led=%h want all zero",
                     b0.phase, b0.score_a, b0.score_b, b0.shot_valid, b0.shot_hit, b0.err, b0.winner, b0.led);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (b0.phase !== 3'd1) begin
            failures++;
            $display("FAIL start_held_through_reset: got phase=%0d want 1", b0.phase);
        end
        idle0();
    endtask

    task automatic test_placement();
        drive0(1, 0, 1, 2);
        checks++;
        if (b0.err !== 1'b0) begin failures++; $display("FAIL place_free_err: got %0d want 0", b0.err); end
        idle0();
        drive0(1, 0, 1, 2);
        checks++;
        if ({b0.err, b0.phase} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL place_dup_err: got err=%0d phase=%0d want err=1 phase=1", b0.err, b0.phase);
        end
        idle0();
        checks++;
        if (b0.err !== 1'b0) begin failures++; $display("FAIL err_one_cycle: got %0d want 0", b0.err); end
        place0(1, 0, 0, 0);
        place0(1, 0, 1, 1);
        checks++;
        if (b0.phase !== 3'd1) begin failures++; $display("FAIL count_after_err: got phase=%0d want 1", b0.phase); end
        drive0(1, 0, 2, 2);
        checks++;
        if (b0.phase !== 3'd2) begin failures++; $display("FAIL enter_place_b: got phase=%0d want 2", b0.phase); end
        idle0();
        place0(1, 0, 3, 3);
        place0(0, 1, 0, 0);
        drive0(0, 1, 0, 0);
        checks++;
        if ({b0.err, b0.phase} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL place_b_dup: got err=%0d phase=%0d want err=1 phase=2", b0.err, b0.phase);
        end
        idle0();
        place0(0, 1, 1, 1);
        place0(0, 1, 2, 2);
        checks++;
        if (b0.phase !== 3'd2) begin failures++; $display("FAIL place_b_count: got phase=%0d want 2", b0.phase); end
        place0(0, 1, 3, 3);
        checks++;
        if (b0.phase !== 3'd3) begin failures++; $display("FAIL enter_shoot_a: got phase=%0d want 3", b0.phase); end
        b0.start = 1'b1;
        tick();
        checks++;
        if (b0.phase !== 3'd3) begin failures++; $display("FAIL start_ignored: got phase=%0d want 3", b0.phase); end
        idle0();
    endtask

    task automatic test_first_hit();
        shoot0(1, 0, 0, 0, mk(1, 1, 0, 3));
        checks++;
        if ({b0.shot_hit, b0.shot_valid} !== 2'b10) begin
            failures++;
            $display("FAIL hit_held: got shot_hit=%0d shot_valid=%0d want 1 0", b0.shot_hit, b0.shot_valid);
        end
    endtask

    task automatic test_turns();
        shoot0(1, 0, 0, 1, mk(0, 1, 0, 4));
        place0(1, 0, 1, 1);
        checks++;
        if ({b0.phase, b0.score_a} !== {3'd4, 4'd1}) begin
            failures++;
            $display("FAIL inactive_ignored: got phase=%0d sa=%0d want 4 1", b0.phase, b0.score_a);
        end
        shoot0(1, 1, 1, 2, mk(1, 1, 1, 4));
        shoot0(0, 1, 3, 0, mk(0, 1, 1, 3));
    endtask

    task automatic test_win();
        shoot0(1, 0, 1, 1, mk(1, 2, 1, 3));
        shoot0(1, 0, 1, 1, mk(0, 2, 1, 4));
        shoot0(0, 1, 3, 3, mk(0, 2, 1, 3));
        shoot0(1, 0, 2, 2, mk(1, 3, 1, 3));
        shoot0(1, 0, 3, 3, mk(1, 4, 1, 5));
        checks++;
        if ({b0.winner, b0.led} !== {2'b01, 8'h41}) begin
            failures++;
            $display("FAIL win_a: got winner=%0d led=%h want 1 41", b0.winner, b0.led);
        end
        place0(1, 0, 0, 0);
        place0(0, 1, 0, 0);
        checks++;
        if ({b0.phase, b0.score_a, b0.score_b} !== {3'd5, 4'd4, 4'd1}) begin
            failures++;
            $display("FAIL done_buttons: got phase=%0d sa=%0d sb=%0d want 5 4 1", b0.phase, b0.score_a, b0.score_b);
        end
        b0.start = 1'b1;
        tick();
        checks++;
        if ({b0.phase, b0.score_a, b0.winner, b0.shot_hit} !== {3'd0, 4'd4, 2'b01, 1'b1}) begin
            failures++;
            $display("FAIL done_to_idle: got phase=%0d sa=%0d winner=%0d hit=%0d want 0 4 1 1",
                     b0.phase, b0.score_a, b0.winner, b0.shot_hit);
        end
        b0.start = 1'b0;
        tick();
        b0.X = 2'd0; b0.Y = 2'd0; b0.pAb = 1'b1; b0.start = 1'b1;
        tick();
        checks++;
        if ({b0.phase, b0.score_a, b0.score_b, b0.winner, b0.shot_hit} !== {3'd1, 4'd0, 4'd0, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL new_game_clear: got phase=%0d sa=%0d sb=%0d winner=%0d hit=%0d want 1 0 0 0 0",
                     b0.phase, b0.score_a, b0.score_b, b0.winner, b0.shot_hit);
        end
        b0.start = 1'b0;
        tick();
        idle0();
        drive0(1, 0, 0, 0);
        checks++;
        if (b0.err !== 1'b0) begin failures++; $display("FAIL held_level_no_event: got err=%0d want 0", b0.err); end
        idle0();
        drive0(1, 0, 0, 0);
        checks++;
        if (b0.err !== 1'b1) begin failures++; $display("FAIL place_after_held: got err=%0d want 1", b0.err); end
        idle0();
    endtask

    task automatic test_wide_board();
        b3.start = 1'b0; b3.pAb = 1'b0; b3.pBb = 1'b0;
        rst3 = 1'b0;
        b3.start = 1'b1;
        tick();
        b3.start = 1'b0;
        tick();
        checks++;
        if (b3.phase !== 3'd1) begin failures++; $display("FAIL wide_place_a: got phase=%0d want 1", b3.phase); end
        for (int i = 0; i < 8; i++) place3(1, 0, i, i);
        place3(1, 0, 7, 0);
        checks++;
        if (b3.phase !== 3'd1) begin failures++; $display("FAIL wide_count9: got phase=%0d want 1", b3.phase); end
        place3(1, 0, 0, 7);
        checks++;
        if (b3.phase !== 3'd2) begin failures++; $display("FAIL wide_place_b: got phase=%0d want 2", b3.phase); end
        for (int i = 0; i < 8; i++) place3(0, 1, i, i);
        drive3(0, 1, 7, 7);
        checks++;
        if (b3.err !== 1'b1) begin failures++; $display("FAIL wide_dup_77: got err=%0d want 1", b3.err); end
        b3.pBb = 1'b0;
        tick();
        place3(0, 1, 7, 0);
        place3(0, 1, 0, 7);
        checks++;
        if (b3.phase !== 3'd3) begin failures++; $display("FAIL wide_shoot_a: got phase=%0d want 3", b3.phase); end
        shoot3(1, 0, 7, 7, mk(1, 1, 0, 3));
        shoot3(1, 0, 6, 7, mk(0, 1, 0, 4));
        b3.X = 3'd0; b3.Y = 3'd0; b3.pBb = 1'b1;
        rst3 = 1'b1;
        tick();
        checks++;
        if ({b3.phase, b3.score_a, b3.score_b, b3.shot_valid, b3.shot_hit, b3.err, b3.winner, b3.led} !== 24'd0) begin
            failures++;
            $display("FAIL wide_mid_reset: got phase=%0d sa=%0d sb=%0d sv=%0d sh=%0d err=%0d win=%0d led=%h want all zero",
                     b3.phase, b3.score_a, b3.score_b, b3.shot_valid, b3.shot_hit, b3.err, b3.winner, b3.led);
        end
        rst3 = 1'b0;
        b3.pBb = 1'b0;
        tick();
        checks++;
        if (b3.phase !== 3'd0) begin failures++; $display("FAIL wide_after_reset: got phase=%0d want 0", b3.phase); end
    endtask

    initial begin
        b0.start = 1'b0; b0.X = '0; b0.Y = '0; b0.pAb = 1'b0; b0.pBb = 1'b0;
        b3.start = 1'b0; b3.X = '0; b3.Y = '0; b3.pAb = 1'b0; b3.pBb = 1'b0;
        test_reset();
        test_placement();
        test_first_hit();
        test_turns();
        test_win();
        test_wide_board();
        tick();
        checks++;
        if (q0.size() != 0) begin failures++; $display("FAIL shots0_pending: got %0d outstanding want 0", q0.size()); end
        checks++;
        if (q3.size() != 0) begin failures++; $display("FAIL shots3_pending: got %0d outstanding want 0", q3.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
